// File: rtl/writeback_unit.sv
// Writeback unit: arbitrates ALU and LSU results onto one register file write port.
// Load results are buffered in a small FIFO; a 32-entry busy scoreboard tracks
// outstanding register writes.
// Optional feature macro: WB_BYPASS_EN adds writeback forwarding outputs.
module writeback_unit #(
    parameter int LSU_FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        rs1_busy,
    output logic        rs2_busy,
`ifdef WB_BYPASS_EN
    output logic        rs1_fwd,
    output logic        rs2_fwd,
    output logic [31:0] rs1_fwd_data,
    output logic [31:0] rs2_fwd_data,
`endif
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        rd_we
);

    localparam int PTR_W = (LSU_FIFO_DEPTH > 1) ? $clog2(LSU_FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LSU_FIFO_DEPTH);

    logic [LSU_FIFO_DEPTH-1:0][4:0]  fifo_rd_q, fifo_rd_d;
    logic [LSU_FIFO_DEPTH-1:0][31:0] fifo_data_q, fifo_data_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic        rd_we_q, rd_we_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [31:0] busy_q, busy_d;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    // No push/pop on a full FIFO in one cycle, so ready simply tracks "not full".
    assign lsu_ready  = !fifo_full && !rst;
    assign push       = lsu_valid && lsu_ready;
    assign pop        = !alu_valid && !fifo_empty;

    // Load-result FIFO: write at the tail on accept, advance the head on pop.
    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push) begin
            fifo_rd_d[wr_ptr_q]   = lsu_rd;
            fifo_data_d[wr_ptr_q] = lsu_data;
            wr_ptr_d              = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Writeback select: ALU always wins, otherwise drain the FIFO head; x0 writes are suppressed.
    always_comb begin
        rd_we_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        if (alu_valid) begin
            rd_we_d   = (alu_rd != 5'd0);
            rd_addr_d = alu_rd;
            rd_data_d = alu_data;
        end else if (pop) begin
            rd_we_d   = (fifo_rd_q[rd_ptr_q] != 5'd0);
            rd_addr_d = fifo_rd_q[rd_ptr_q];
            rd_data_d = fifo_data_q[rd_ptr_q];
        end
    end

    // Scoreboard: clear on the retiring write, then apply the issue set so a same-edge set wins.
    always_comb begin
        busy_d = busy_q;
        if (rd_we_q) begin
            busy_d[rd_addr_q] = 1'b0;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Control state, output registers and scoreboard, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_we_q   <= 1'b0;
            rd_addr_q <= 5'd0;
            rd_data_q <= 32'd0;
            busy_q    <= 32'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_we_q   <= rd_we_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            busy_q    <= busy_d;
        end
    end

    // FIFO storage needs no reset; the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        fifo_rd_q   <= fifo_rd_d;
        fifo_data_q <= fifo_data_d;
    end

    assign rd_we   = rd_we_q;
    assign rd_addr = rd_addr_q;
    assign rd_data = rd_data_q;

`ifdef WB_BYPASS_EN
    // Forward the value being written this cycle; the register only stays busy if re-issued now.
    always_comb begin
        rs1_fwd      = 1'b0;
        rs1_fwd_data = 32'd0;
        rs1_busy     = busy_q[rs1_addr];
        rs2_fwd      = 1'b0;
        rs2_fwd_data = 32'd0;
        rs2_busy     = busy_q[rs2_addr];
        if (rd_we_q && (rd_addr_q == rs1_addr) && (rs1_addr != 5'd0)) begin
            rs1_fwd      = 1'b1;
            rs1_fwd_data = rd_data_q;
            rs1_busy     = issue_valid && (issue_rd == rs1_addr);
        end
        if (rd_we_q && (rd_addr_q == rs2_addr) && (rs2_addr != 5'd0)) begin
            rs2_fwd      = 1'b1;
            rs2_fwd_data = rd_data_q;
            rs2_busy     = issue_valid && (issue_rd == rs2_addr);
        end
    end
`else
    assign rs1_busy = busy_q[rs1_addr];
    assign rs2_busy = busy_q[rs2_addr];
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Testbench for writeback_unit: vector table plus scoreboard-based corner sequences.
module tb_writeback_unit;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_busy;
    logic        rs2_busy;
`ifdef WB_BYPASS_EN
    logic        rs1_fwd;
    logic        rs2_fwd;
    logic [31:0] rs1_fwd_data;
    logic [31:0] rs2_fwd_data;
`endif
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_we;

    writeback_unit #(.LSU_FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
`ifdef WB_BYPASS_EN
        .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
        .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data),
`endif
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_we(rd_we)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldata;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        ewe;
        logic [4:0]  eaddr;
        logic [31:0] edata;
        logic        echk;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        chk;
    } exp_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    vec_t        vecs [9];
    exp_t        expQ [$];
    ent_t        mFifo [$];
    logic [31:0] mBusy;
    logic        mWe;
    logic [4:0]  mAddr;
    logic [31:0] mData;
    logic        mKnown;
    logic        lastAccept;
    int          passCnt;
    int          totalCnt;
    int          lsuIdx;

    // One comparison; every failing check prints a FAIL line.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic idleInputs();
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
        issue_valid = 1'b0; issue_rd = 5'd0;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
    endtask

    task automatic applyStimulus(input vec_t v);
        alu_valid = v.av; alu_rd = v.ard; alu_data = v.adata;
        lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ldata;
        issue_valid = v.iv; issue_rd = v.ird;
        rs1_addr = v.rs1; rs2_addr = v.rs2;
    endtask

    // Check combinational outputs, advance the model, clock once, then check the registered write.
    task automatic stepCycle();
        exp_t        e;
        ent_t        h;
        ent_t        n;
        logic [31:0] nb;
        logic        mReady;
        logic        eb1;
        logic        eb2;
        #1;
        mReady = (mFifo.size() < DEPTH);
        checkOutput("lsu_ready", {31'd0, lsu_ready}, {31'd0, mReady});
        eb1 = mBusy[rs1_addr];
        eb2 = mBusy[rs2_addr];
`ifdef WB_BYPASS_EN
        if (mWe && mAddr == rs1_addr && rs1_addr != 5'd0) begin
            eb1 = issue_valid && issue_rd == rs1_addr;
            checkOutput("rs1_fwd", {31'd0, rs1_fwd}, 32'd1);
            checkOutput("rs1_fwd_data", rs1_fwd_data, mData);
        end else begin
            checkOutput("rs1_fwd", {31'd0, rs1_fwd}, 32'd0);
            checkOutput("rs1_fwd_data", rs1_fwd_data, 32'd0);
        end
        if (mWe && mAddr == rs2_addr && rs2_addr != 5'd0) begin
            eb2 = issue_valid && issue_rd == rs2_addr;
        end
`endif
        checkOutput("rs1_busy", {31'd0, rs1_busy}, {31'd0, eb1});
        checkOutput("rs2_busy", {31'd0, rs2_busy}, {31'd0, eb2});
        lastAccept = lsu_valid && mReady;
        nb = mBusy;
        if (mWe) nb[mAddr] = 1'b0;
        if (issue_valid && issue_rd != 5'd0) nb[issue_rd] = 1'b1;
        nb[0] = 1'b0;
        if (alu_valid) begin
            e = '{alu_rd != 5'd0, alu_rd, alu_data, alu_rd != 5'd0};
        end else if (mFifo.size() > 0) begin
            h = mFifo.pop_front();
            e = '{h.rd != 5'd0, h.rd, h.data, h.rd != 5'd0};
        end else begin
            e = '{1'b0, mAddr, mData, mKnown};
        end
        expQ.push_back(e);
        if (alu_valid || e.we) begin
            mKnown = e.we;
            mAddr  = e.addr;
            mData  = e.data;
        end else if (e.addr != mAddr || e.data != mData || !e.chk) begin
            mKnown = 1'b0;
        end
        mWe   = e.we;
        mBusy = nb;
        if (lastAccept) begin
            n = '{lsu_rd, lsu_data};
            mFifo.push_back(n);
        end
        @(posedge clk);
        #1;
        e = expQ.pop_front();
        checkOutput("rd_we", {31'd0, rd_we}, {31'd0, e.we});
        if (e.chk) begin
            checkOutput("rd_addr", {27'd0, rd_addr}, {27'd0, e.addr});
            checkOutput("rd_data", rd_data, e.data);
        end
    endtask

    // Synchronous reset for one edge, then verify the cleared state and reset the model.
    task automatic doReset();
        idleInputs();
        rst = 1'b1;
        #1;
        checkOutput("ready_in_reset", {31'd0, lsu_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_rd_we", {31'd0, rd_we}, 32'd0);
        checkOutput("reset_rd_addr", {27'd0, rd_addr}, 32'd0);
        checkOutput("reset_rd_data", rd_data, 32'd0);
        mFifo.delete();
        expQ.delete();
        mBusy = 32'd0; mWe = 1'b0; mAddr = 5'd0; mData = 32'd0; mKnown = 1'b1;
        stepCycle();
    endtask

    initial begin
        passCnt = 0;
        totalCnt = 0;
        rst = 1'b1;
        idleInputs();
        mBusy = 32'd0; mWe = 1'b0; mAddr = 5'd0; mData = 32'd0; mKnown = 1'b1;
        lastAccept = 1'b0;

        //           av    ard    adata          lv    lrd    ldata     iv    ird    rs1    rs2    ewe   eaddr  edata          echk
        vecs[0] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,    1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 5'd0, 32'h0,         1'b1};
        vecs[1] = '{1'b1, 5'd5, 32'hDEADBEEF,  1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd5, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF,  1'b1};
        vecs[2] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 5'd5, 32'hDEADBEEF,  1'b1};
        vecs[3] = '{1'b1, 5'd0, 32'h1234,      1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,         1'b0};
        vecs[4] = '{1'b1, 5'd3, 32'h1,         1'b1, 5'd4, 32'h2,    1'b1, 5'd4, 5'd3, 5'd4, 1'b1, 5'd3, 32'h1,         1'b1};
        vecs[5] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd0, 5'd4, 1'b1, 5'd4, 32'h2,         1'b1};
        vecs[6] = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd6, 32'hA5,   1'b0, 5'd0, 5'd0, 5'd4, 1'b0, 5'd4, 32'h2,         1'b1};
        vecs[7] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd6, 5'd0, 1'b1, 5'd6, 32'hA5,        1'b1};
        vecs[8] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd6, 5'd0, 1'b0, 5'd6, 32'hA5,        1'b1};

        repeat (2) @(posedge clk);
        #1;
        doReset();

        $display("[TB] vector table");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            stepCycle();
            checkOutput($sformatf("vec%0d_we", i), {31'd0, rd_we}, {31'd0, vecs[i].ewe});
            if (vecs[i].echk) begin
                checkOutput($sformatf("vec%0d_addr", i), {27'd0, rd_addr}, {27'd0, vecs[i].eaddr});
                checkOutput($sformatf("vec%0d_data", i), rd_data, vecs[i].edata);
            end
        end

        $display("[TB] ALU streak with LSU backpressure");
        lsuIdx = 0;
        for (int c = 0; c < 12; c++) begin
            idleInputs();
            alu_valid = (c < 4);
            alu_rd    = 5'(10 + c);
            alu_data  = 32'h100 + 32'(c);
            lsu_valid = (lsuIdx < 3);
            lsu_rd    = 5'(20 + lsuIdx);
            lsu_data  = 32'h200 + 32'(lsuIdx);
            if (c == 2) begin
                #1;
                checkOutput("ready_low_when_full", {31'd0, lsu_ready}, 32'd0);
            end
            stepCycle();
            if (lastAccept) lsuIdx++;
        end
        idleInputs();
        #1;
        checkOutput("ready_after_drain", {31'd0, lsu_ready}, 32'd1);

        $display("[TB] set wins over clear");
        idleInputs(); issue_valid = 1'b1; issue_rd = 5'd7; stepCycle();
        idleInputs(); alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77; stepCycle();
        idleInputs(); issue_valid = 1'b1; issue_rd = 5'd7; stepCycle();
        idleInputs(); rs1_addr = 5'd7;
        #1;
        checkOutput("x7_still_busy", {31'd0, rs1_busy}, 32'd1);
        stepCycle();
        idleInputs(); alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h78; stepCycle();
        idleInputs(); rs1_addr = 5'd7; stepCycle();
        idleInputs(); rs1_addr = 5'd7;
        #1;
        checkOutput("x7_cleared", {31'd0, rs1_busy}, 32'd0);
        stepCycle();

        $display("[TB] reset with pending state");
        idleInputs(); issue_valid = 1'b1; issue_rd = 5'd9;
        alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hB;
        lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 32'hC; stepCycle();
        idleInputs(); alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'hD;
        lsu_valid = 1'b1; lsu_rd = 5'd14; lsu_data = 32'hE; rs1_addr = 5'd9; stepCycle();
        doReset();
        idleInputs(); rs1_addr = 5'd9;
        #1;
        checkOutput("x9_busy_after_reset", {31'd0, rs1_busy}, 32'd0);
        checkOutput("ready_after_reset", {31'd0, lsu_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            idleInputs(); rs1_addr = 5'd9; stepCycle();
            checkOutput("no_write_after_reset", {31'd0, rd_we}, 32'd0);
        end
        idleInputs(); issue_valid = 1'b1; issue_rd = 5'd9; stepCycle();
        idleInputs(); alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99; stepCycle();
        idleInputs(); rs1_addr = 5'd9;
`ifdef WB_BYPASS_EN
        #1;
        checkOutput("x9_fwd", {31'd0, rs1_fwd}, 32'd1);
        checkOutput("x9_fwd_data", rs1_fwd_data, 32'h99);
`endif
        stepCycle();
        idleInputs(); stepCycle();

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
